// File: rtl/dds_phase_accum.sv
// Dual-channel DDS phase accumulator: captures tuning words on the receiver's
// done edge and applies them together at a sample-tick boundary.
module dds_phase_accum #(
  parameter int PHASE_W = 24,
  parameter int FREQ_W  = 16,
  parameter int OUT_W   = 8,
  parameter int DIV     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              done,
  input  logic [FREQ_W-1:0] freq0,
  input  logic [FREQ_W-1:0] freq1,
  input  logic              phase_sync,
  output logic [OUT_W-1:0]  phase0,
  output logic [OUT_W-1:0]  phase1,
  output logic              sample_valid,
  output logic              update_ack,
  output logic              pending
);
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, PENDING = 2'd1, ACK = 2'd2} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                done_d_q;
  logic                recap_q, recap_d;
  logic [FREQ_W-1:0]   shadow0_q, shadow0_d, shadow1_q, shadow1_d;
  logic [FREQ_W-1:0]   active0_q, active0_d, active1_q, active1_d;
  logic [PHASE_W-1:0]  acc0_q, acc0_d, acc1_q, acc1_d;
  logic                sample_valid_q, update_ack_q, pending_q;
  logic                cap, tick, apply;

  assign cap   = done & ~done_d_q;
  assign tick  = (cnt_q == CNT_W'(DIV - 1));
  assign apply = (state_q == PENDING) & tick;

  always_comb begin
    cnt_d     = tick ? '0 : CNT_W'(cnt_q + 1'b1);
    shadow0_d = cap ? freq0 : shadow0_q;
    shadow1_d = cap ? freq1 : shadow1_q;
    // The apply tick still steps with the old words; the new ones take over next tick.
    active0_d = apply ? shadow0_q : active0_q;
    active1_d = apply ? shadow1_q : active1_q;
    acc0_d    = acc0_q;
    acc1_d    = acc1_q;
    if (apply && phase_sync) begin
      acc0_d = '0;
      acc1_d = '0;
    end else if (tick) begin
      acc0_d = acc0_q + PHASE_W'(active0_q);
      acc1_d = acc1_q + PHASE_W'(active1_q);
    end
    // Remember a capture landing on the apply tick so ACK re-arms PENDING.
    recap_d = apply & cap;
    state_d = IDLE;
    case (state_q)
      IDLE:    state_d = cap ? PENDING : IDLE;
      PENDING: state_d = tick ? ACK : PENDING;
      ACK:     state_d = (cap | recap_q) ? PENDING : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      done_d_q       <= 1'b0;
      recap_q        <= 1'b0;
      shadow0_q      <= '0;
      shadow1_q      <= '0;
      active0_q      <= '0;
      active1_q      <= '0;
      acc0_q         <= '0;
      acc1_q         <= '0;
      sample_valid_q <= 1'b0;
      update_ack_q   <= 1'b0;
      pending_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      done_d_q       <= done;
      recap_q        <= recap_d;
      shadow0_q      <= shadow0_d;
      shadow1_q      <= shadow1_d;
      active0_q      <= active0_d;
      active1_q      <= active1_d;
      acc0_q         <= acc0_d;
      acc1_q         <= acc1_d;
      sample_valid_q <= tick;
      update_ack_q   <= (state_d == ACK);
      pending_q      <= (state_d == PENDING);
    end
  end

  assign phase0       = acc0_q[PHASE_W-1 -: OUT_W];
  assign phase1       = acc1_q[PHASE_W-1 -: OUT_W];
  assign sample_valid = sample_valid_q;
  assign update_ack   = update_ack_q;
  assign pending      = pending_q;
endmodule

// File: tb/tb_dds_phase_accum.sv
// Directed and random stimulus for dds_phase_accum, checked every cycle against
// a behavioural model built from the word-capture/apply/tick rules.
module tb_dds_phase_accum;
  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        done = 1'b0;
  logic [15:0] freq0 = '0, freq1 = '0;
  logic        phase_sync = 1'b0;
  logic [7:0]  phase0, phase1;
  logic        sample_valid, update_ack, pending;

  dds_phase_accum #(.PHASE_W(24), .FREQ_W(16), .OUT_W(8), .DIV(DIV)) dut (
    .clk(clk), .rst_n(rst_n), .done(done), .freq0(freq0), .freq1(freq1),
    .phase_sync(phase_sync), .phase0(phase0), .phase1(phase1),
    .sample_valid(sample_valid), .update_ack(update_ack), .pending(pending)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0, ack_cnt = 0;

  // Reference model state
  longint m_cycles, m_acc0, m_acc1;
  int     m_sh0, m_sh1, m_act0, m_act1;
  bit     m_prev_done, m_pend, m_ack, m_recap, m_sv;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cycles = 0; m_acc0 = 0; m_acc1 = 0;
    m_sh0 = 0; m_sh1 = 0; m_act0 = 0; m_act1 = 0;
    m_prev_done = 0; m_pend = 0; m_ack = 0; m_recap = 0; m_sv = 0;
  endtask

  task automatic model_step();
    bit tick, cap, n_pend, n_ack;
    tick = (m_cycles % DIV) == (DIV - 1);
    cap  = done && !m_prev_done;
    n_pend = 0; n_ack = 0;
    if (m_pend && tick) begin
      if (phase_sync) begin
        m_acc0 = 0; m_acc1 = 0;
      end else begin
        m_acc0 = (m_acc0 + m_act0) % (64'd1 << 24);
        m_acc1 = (m_acc1 + m_act1) % (64'd1 << 24);
      end
      m_act0 = m_sh0; m_act1 = m_sh1;
      n_ack = 1;
      m_recap = cap;
    end else begin
      if (tick) begin
        m_acc0 = (m_acc0 + m_act0) % (64'd1 << 24);
        m_acc1 = (m_acc1 + m_act1) % (64'd1 << 24);
      end
      if (m_ack) n_pend = cap || m_recap;
      else       n_pend = m_pend || cap;
      m_recap = 0;
    end
    if (cap) begin
      m_sh0 = int'(freq0); m_sh1 = int'(freq1);
    end
    m_sv = tick;
    m_pend = n_pend;
    m_ack = n_ack;
    m_prev_done = done;
    m_cycles++;
  endtask

  task automatic check_outs();
    chk("phase0", 32'(phase0), 32'(m_acc0 >> 16));
    chk("phase1", 32'(phase1), 32'(m_acc1 >> 16));
    chk("sample_valid", 32'(sample_valid), 32'(m_sv));
    chk("update_ack", 32'(update_ack), 32'(m_ack));
    chk("pending", 32'(pending), 32'(m_pend));
  endtask

  // One clock: drive at negedge, advance model, sample at next negedge.
  task automatic cyc(input bit d, input bit ps);
    done = d; phase_sync = ps;
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_outs();
    if (update_ack) ack_cnt++;
  endtask

  task automatic run(input int n, input bit ps);
    for (int i = 0; i < n; i++) cyc(1'b0, ps);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      done = ~done;
      @(negedge clk);
    end
    chk("rst_phase0", 32'(phase0), 0);
    chk("rst_phase1", 32'(phase1), 0);
    chk("rst_sv", 32'(sample_valid), 0);
    chk("rst_ack", 32'(update_ack), 0);
    chk("rst_pending", 32'(pending), 0);
    done = 1'b0;
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic wait_ack(input bit ps);
    int k = 0;
    while (update_ack !== 1'b1 && k < 64) begin
      cyc(1'b0, ps);
      k++;
    end
    chk("ack_timeout", 32'(k < 64), 1);
  endtask

  task automatic wait_sv();
    int k = 0;
    while (sample_valid !== 1'b1 && k < 64) begin
      cyc(1'b0, 1'b0);
      k++;
    end
    chk("sv_timeout", 32'(k < 64), 1);
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    // Reset with done toggling, then free-run ticks
    do_reset();
    run(12, 1'b0);

    // Load 0x0100 / 0x0040
    freq0 = 16'h0100; freq1 = 16'h0040;
    ack_cnt = 0;
    cyc(1'b1, 1'b0);
    chk("load_pending", 32'(pending), 1);
    wait_ack(1'b0);
    run(256 * DIV, 1'b0);
    chk("load_phase0_256", 32'(phase0), 32'h01);
    chk("load_phase1_256", 32'(phase1), 32'h00);
    run(768 * DIV, 1'b0);
    chk("load_phase1_1024", 32'(phase1), 32'h01);
    chk("load_ack_count", 32'(ack_cnt), 1);

    // Wrap with 0xFFFF, accumulators zeroed at apply
    freq0 = 16'hFFFF; freq1 = 16'h0000;
    cyc(1'b1, 1'b1);
    wait_ack(1'b1);
    run(256 * DIV, 1'b0);
    chk("wrap_phase0_256", 32'(phase0), 32'hFF);
    run(DIV, 1'b0);
    chk("wrap_phase0_257", 32'(phase0), 32'h00);

    // Latest wins: two captures before one tick
    wait_sv();
    ack_cnt = 0;
    freq0 = 16'h1111; cyc(1'b1, 1'b1);
    cyc(1'b0, 1'b1);
    freq0 = 16'h2222; cyc(1'b1, 1'b1);
    cyc(1'b0, 1'b1);
    wait_ack(1'b1);
    run(16 * DIV, 1'b0);
    chk("latest_ack_count", 32'(ack_cnt), 1);
    chk("latest_phase0", 32'(phase0), 32'h02);

    // Done held high for 10 cycles
    ack_cnt = 0;
    freq0 = 16'h0500;
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0);
    run(10, 1'b0);
    chk("held_ack_count", 32'(ack_cnt), 1);

    // Reset while a word is pending
    wait_sv();
    cyc(1'b1, 1'b0);
    chk("midrst_pending", 32'(pending), 1);
    do_reset();
    ack_cnt = 0;
    run(20, 1'b0);
    chk("midrst_ack_count", 32'(ack_cnt), 0);
    chk("midrst_phase0", 32'(phase0), 0);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        freq0 = 16'($urandom);
        freq1 = 16'($urandom);
      end
      cyc(bit'($urandom_range(0, 5) == 0), bit'($urandom_range(0, 3) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
